// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix bytes, receive FSM encoding and key-word layout.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  localparam int KEY_EXT_BIT  = 8;
  localparam int KEY_CODE_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the PS/2 pins, glitch-filters ps2_clk and emits a 1-cycle pulse on each
// filtered falling edge, together with the synchronised data pin.
module ps2_clk_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic fall_pulse,
  output logic dat_sync
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   fall_q, fall_d;
  logic                   clk_synced;

  assign clk_synced = clk_sync_q[SYNC_STAGES-1];
  assign dat_sync   = dat_sync_q[SYNC_STAGES-1];
  assign fall_pulse = fall_q;

  // A level change is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
    cnt_d      = '0;
    filt_d     = filt_q;
    fall_d     = 1'b0;
    if (clk_synced != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = clk_synced;
        fall_d = ~clk_synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      cnt_q      <= '0;
      filt_q     <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      cnt_q      <= cnt_d;
      filt_q     <= filt_d;
      fall_q     <= fall_d;
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: deframes device-to-host frames, resolves E0/F0 prefixes and
// emits one 9-bit key word per make code with a 1-cycle key_valid strobe.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 27000
) (
  input  logic       clock27,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [8:0] keyDataOut,
  output logic       key_valid,
  output logic       frame_error
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic fall_pulse;
  logic dat_sync;

  ps2_clk_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk       (clock27),
    .rst_n     (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .fall_pulse(fall_pulse),
    .dat_sync  (dat_sync)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_ok_q, parity_ok_d;
  logic [TO_W-1:0] timeout_q, timeout_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [8:0]      key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            frame_error_q, frame_error_d;

  assign keyDataOut  = key_q;
  assign key_valid   = key_valid_q;
  assign frame_error = frame_error_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_ok_d   = parity_ok_q;
    ext_d         = ext_q;
    brk_d         = brk_q;
    key_d         = key_q;
    key_valid_d   = 1'b0;
    frame_error_d = 1'b0;

    if (state_q == ST_IDLE || fall_pulse) begin
      timeout_d = '0;
    end else begin
      timeout_d = timeout_q + 1'b1;
    end

    // A stalled partial frame is abandoned along with any pending prefix.
    if (state_q != ST_IDLE && !fall_pulse && timeout_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_d       = ST_IDLE;
      timeout_d     = '0;
      frame_error_d = 1'b1;
      ext_d         = 1'b0;
      brk_d         = 1'b0;
    end else if (fall_pulse) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!dat_sync) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
          parity_ok_d = odd_parity_ok(shift_q, dat_sync);
          state_d     = ST_STOP;
        end
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dat_sync && parity_ok_q) begin
            if (shift_q == PS2_EXT_PREFIX) begin
              ext_d = 1'b1;
            end else if (shift_q == PS2_BREAK_PREFIX) begin
              brk_d = 1'b1;
            end else begin
              if (!brk_q) begin
                key_d[KEY_EXT_BIT]     = ext_q;
                key_d[KEY_CODE_MSB:0]  = shift_q;
                key_valid_d            = 1'b1;
              end
              ext_d = 1'b0;
              brk_d = 1'b0;
            end
          end else begin
            frame_error_d = 1'b1;
            ext_d         = 1'b0;
            brk_d         = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_ok_q   <= 1'b0;
      timeout_q     <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      key_q         <= '0;
      key_valid_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_ok_q   <= parity_ok_d;
      timeout_q     <= timeout_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      key_q         <= key_d;
      key_valid_q   <= key_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench for ps2_key_receiver: a keyboard model drives whole frames and the
// observed key words, strobe counts and error counts are compared with hand-worked values.
module tb_ps2_key_receiver;

   // The keyboard model runs a faster ps2_clk than a real keyboard so the run stays short;
   // the receiver does not depend on the actual bit rate.
   localparam int HALF = 40;

   logic       clock27;
   logic       reset_n;
   logic       ps2_clk;
   logic       ps2_dat;
   logic [8:0] keyDataOut;
   logic       key_valid;
   logic       frame_error;

   int vectorCount = 0;
   int miscompareCount = 0;
   int cycleCount = 0;
   int validCount = 0;
   int errorCount = 0;
   int bothCount = 0;
   int lastErrCycle = 0;
   int lastFallCycle = 0;
   int validBase;
   int errorBase;

   ps2_key_receiver dut (
      .clock27    (clock27),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_dat    (ps2_dat),
      .keyDataOut (keyDataOut),
      .key_valid  (key_valid),
      .frame_error(frame_error)
   );

   // 27 MHz-style free-running system clock
   initial clock27 = 1'b0;
   always #5 clock27 = ~clock27;

   // Cycle counter used to time the frame timeout against the last ps2_clk edge
   always @(posedge clock27) cycleCount <= cycleCount + 1;

   // Monitor samples the strobes on the falling system-clock edge, away from updates,
   // and tallies key_valid / frame_error pulses plus any cycle where both are high
   always @(negedge clock27) begin
      if (key_valid) validCount++;
      if (frame_error) begin
         errorCount++;
         lastErrCycle = cycleCount;
      end
      if (key_valid && frame_error) bothCount++;
   end

   // Watchdog so a stuck run still terminates with a report
   initial begin
      repeat (200000) @(posedge clock27);
      $display("[TB] FAIL watchdog: observed run still active, expected finish before 200000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         miscompareCount++;
         $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
      end
   endtask

   // One PS/2 bit cell: data set while clock is high, then a low half-period.
   // With glitch set, a 1-clock low spike is injected in the high phase and a
   // 1-clock high spike in the low phase.
   task automatic ps2Bit(input logic b, input bit glitch);
      ps2_dat = b;
      repeat (HALF / 2) @(negedge clock27);
      if (glitch) begin
         ps2_clk = 1'b0;
         @(negedge clock27);
         ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(negedge clock27);
      ps2_clk = 1'b0;
      lastFallCycle = cycleCount;
      repeat (HALF / 2) @(negedge clock27);
      if (glitch) begin
         ps2_clk = 1'b1;
         @(negedge clock27);
         ps2_clk = 1'b0;
      end
      repeat (HALF / 2) @(negedge clock27);
      ps2_clk = 1'b1;
   endtask

   // Whole 11-bit frame with optional parity corruption, forced stop level and glitches
   task automatic applyStimulus(input logic [7:0] data, input bit badParity,
                                input logic stopBit, input bit glitch);
      logic par;
      par = (~^data) ^ badParity;
      ps2Bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) ps2Bit(data[i], glitch && (i == 3));
      ps2Bit(par, 1'b0);
      ps2Bit(stopBit, 1'b0);
      ps2_dat = 1'b1;
      repeat (HALF) @(negedge clock27);
   endtask

   // Start bit plus nBits data bits, then the keyboard goes quiet with clock high
   task automatic sendPartial(input int nBits);
      ps2Bit(1'b0, 1'b0);
      for (int i = 0; i < nBits; i++) ps2Bit(i[0], 1'b0);
      ps2_dat = 1'b1;
   endtask

   task automatic snapshot();
      validBase = validCount;
      errorBase = errorCount;
   endtask

   // Directed test sequence
   initial begin
      reset_n = 1'b0;
      ps2_clk = 1'b1;
      ps2_dat = 1'b1;
      repeat (5) @(negedge clock27);
      checkOutput("reset keyDataOut", 32'(keyDataOut), 32'h000);
      checkOutput("reset key_valid", 32'(key_valid), 32'd0);
      checkOutput("reset frame_error", 32'(frame_error), 32'd0);
      reset_n = 1'b1;
      repeat (10) @(negedge clock27);

      $display("[TB] plain make code 1C");
      snapshot();
      applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      checkOutput("t1 valid count", 32'(validCount - validBase), 32'd1);
      checkOutput("t1 error count", 32'(errorCount - errorBase), 32'd0);
      checkOutput("t1 key", 32'(keyDataOut), 32'h01C);

      $display("[TB] extended make and suppressed break codes");
      snapshot();
      applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b1, 1'b0);
      checkOutput("t2 ext valid count", 32'(validCount - validBase), 32'd1);
      checkOutput("t2 ext key", 32'(keyDataOut), 32'h175);
      snapshot();
      applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h75, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'hF0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      checkOutput("t2 break valid count", 32'(validCount - validBase), 32'd0);
      checkOutput("t2 break error count", 32'(errorCount - errorBase), 32'd0);
      checkOutput("t2 break key held", 32'(keyDataOut), 32'h175);

      $display("[TB] parity error then good frame");
      snapshot();
      applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
      checkOutput("t3 parity error count", 32'(errorCount - errorBase), 32'd1);
      checkOutput("t3 parity valid count", 32'(validCount - validBase), 32'd0);
      applyStimulus(8'h32, 1'b0, 1'b1, 1'b0);
      checkOutput("t3 recover key", 32'(keyDataOut), 32'h032);
      checkOutput("t3 recover valid count", 32'(validCount - validBase), 32'd1);

      $display("[TB] bad stop bit and prefix cleared by error");
      snapshot();
      applyStimulus(8'h1C, 1'b0, 1'b0, 1'b0);
      checkOutput("t4 stop error count", 32'(errorCount - errorBase), 32'd1);
      checkOutput("t4 stop valid count", 32'(validCount - validBase), 32'd0);
      applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h1C, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h6B, 1'b0, 1'b1, 1'b0);
      checkOutput("t4 prefix cleared key", 32'(keyDataOut), 32'h06B);
      checkOutput("t4 total error count", 32'(errorCount - errorBase), 32'd2);

      $display("[TB] stalled partial frame times out");
      snapshot();
      sendPartial(4);
      repeat (30000) @(negedge clock27);
      checkOutput("t5 timeout error count", 32'(errorCount - errorBase), 32'd1);
      checkOutput("t5 timeout delay in window",
                  32'((lastErrCycle - lastFallCycle >= 27000) && (lastErrCycle - lastFallCycle <= 27020)),
                  32'd1);
      applyStimulus(8'h29, 1'b0, 1'b1, 1'b0);
      checkOutput("t5 after timeout key", 32'(keyDataOut), 32'h029);
      checkOutput("t5 after timeout error count", 32'(errorCount - errorBase), 32'd1);

      $display("[TB] clock glitches and reset mid-frame");
      snapshot();
      applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1);
      checkOutput("t6 glitch key", 32'(keyDataOut), 32'h05A);
      checkOutput("t6 glitch error count", 32'(errorCount - errorBase), 32'd0);
      applyStimulus(8'hE0, 1'b0, 1'b1, 1'b0);
      sendPartial(3);
      @(negedge clock27);
      reset_n = 1'b0;
      #1;
      checkOutput("t6 reset keyDataOut", 32'(keyDataOut), 32'h000);
      checkOutput("t6 reset key_valid", 32'(key_valid), 32'd0);
      checkOutput("t6 reset frame_error", 32'(frame_error), 32'd0);
      repeat (3) @(negedge clock27);
      reset_n = 1'b1;
      repeat (10) @(negedge clock27);
      snapshot();
      applyStimulus(8'h1C, 1'b0, 1'b1, 1'b0);
      checkOutput("t6 post-reset key", 32'(keyDataOut), 32'h01C);
      checkOutput("t6 post-reset valid count", 32'(validCount - validBase), 32'd1);

      checkOutput("valid and error overlap", 32'(bothCount), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
      $finish;
   end

endmodule
